mem_reservation_station: RTL

//  Load/store buffer feeding the memory address unit. Holds 2 load and 2 store entries.

---
 rtl/mem_rs_pkg.sv | 36 +++
 rtl/mem_rs_entry.sv | 109 ++++++++++
 rtl/mem_reservation_station.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mem_rs_pkg.sv
// Shared types and constants for the memory reservation station.
package mem_rs_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;

    // Fixed RS tags: load entries 9/10, store entries 11/12. Tag 0 means "no producer".
    localparam logic [TAG_W-1:0] LOAD_TAG0  = 4'd9;
    localparam logic [TAG_W-1:0] STORE_TAG0 = 4'd11;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2,
        SENT  = 2'd3
    } rs_state_e;

    typedef struct packed {
        rs_state_e         state;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] addr;
        logic [1:0]        older_stores;
    } mem_rs_entry_t;

    // True when a valid CDB broadcast produces the operand a slot is waiting on.
    function automatic logic tag_hit(input logic             cdb_valid,
                                     input logic [TAG_W-1:0] cdb_tag,
                                     input logic [TAG_W-1:0] q);
        return cdb_valid && (q != '0) && (q == cdb_tag);
    endfunction

endpackage

// File: rtl/mem_rs_entry.sv
// One reservation-station slot: operand capture at issue and from the CDB,
// effective-address add, and the FREE/WAIT/READY/SENT lifecycle.
module mem_rs_entry
    import mem_rs_pkg::*;
#(
    parameter bit               IS_STORE = 1'b0,
    parameter logic [TAG_W-1:0] ENT_TAG  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [TAG_W-1:0]  issue_qk,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic [DATA_W-1:0] issue_imm,
    input  logic [1:0]        older_init,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              selected,
    input  logic              store_sent,
    output mem_rs_entry_t     ent_o
);

    mem_rs_entry_t ent_q, ent_d;

    // Next-state: allocation (with same-cycle CDB bypass), CDB snoop, send and release.
    always_comb begin
        ent_d = ent_q;
        if (alloc) begin
            ent_d.imm = issue_imm;
            ent_d.qj  = issue_qj;
            ent_d.vj  = issue_vj;
            if (tag_hit(cdb_valid, cdb_tag, issue_qj)) begin
                ent_d.qj = '0;
                ent_d.vj = cdb_data;
            end
            if (IS_STORE) begin
                ent_d.qk = issue_qk;
                ent_d.vk = issue_vk;
                if (tag_hit(cdb_valid, cdb_tag, issue_qk)) begin
                    ent_d.qk = '0;
                    ent_d.vk = cdb_data;
                end
                ent_d.older_stores = 2'd0;
            end else begin
                ent_d.qk = '0;
                ent_d.vk = '0;
                ent_d.older_stores = older_init;
            end
            // Only meaningful once qj is clear; recomputed when the base arrives.
            ent_d.addr = ent_d.vj + ent_d.imm;
            if ((ent_d.qj == '0) && (ent_d.qk == '0)) begin
                ent_d.state = READY;
            end else begin
                ent_d.state = WAIT;
            end
        end else begin
            case (ent_q.state)
                WAIT: begin
                    if (tag_hit(cdb_valid, cdb_tag, ent_q.qj)) begin
                        ent_d.qj   = '0;
                        ent_d.vj   = cdb_data;
                        ent_d.addr = cdb_data + ent_q.imm;
                    end
                    if (tag_hit(cdb_valid, cdb_tag, ent_q.qk)) begin
                        ent_d.qk = '0;
                        ent_d.vk = cdb_data;
                    end
                    if ((ent_d.qj == '0) && (ent_d.qk == '0)) begin
                        ent_d.state = READY;
                    end
                end
                READY: begin
                    if (selected) begin
                        if (IS_STORE) begin
                            ent_d.state = FREE;
                        end else begin
                            ent_d.state = SENT;
                        end
                    end
                end
                SENT: begin
                    if (cdb_valid && (cdb_tag == ENT_TAG)) begin
                        ent_d.state = FREE;
                    end
                end
                default: ;
            endcase
            if (!IS_STORE && store_sent && (ent_q.older_stores != 2'd0) &&
                ((ent_q.state == WAIT) || (ent_q.state == READY))) begin
                ent_d.older_stores = ent_q.older_stores - 2'd1;
            end
        end
    end

    // Slot state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    assign ent_o = ent_q;

endmodule

// File: rtl/mem_reservation_station.sv
// Load/store buffer: allocation, store ordering, and one-request-per-cycle selection
// over two load slots (0,1) and two store slots (2,3).
module mem_reservation_station
    import mem_rs_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic              issue_is_store,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [TAG_W-1:0]  issue_qk,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic [DATA_W-1:0] issue_imm,
    output logic              issue_ready,
    output logic [TAG_W-1:0]  issue_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              load1_valid,
    output logic [TAG_W-1:0]  load1_tag,
    output logic [DATA_W-1:0] load1_addr,
    output logic              load2_valid,
    output logic [TAG_W-1:0]  load2_tag,
    output logic [DATA_W-1:0] load2_addr,
    output logic              store1_valid,
    output logic [DATA_W-1:0] store1_addr,
    output logic [DATA_W-1:0] store1_data,
    output logic              store2_valid,
    output logic [DATA_W-1:0] store2_addr,
    output logic [DATA_W-1:0] store2_data
);

    mem_rs_entry_t ent [4];
    logic [3:0]    alloc, sel;
    logic [1:0]    ld_free, ld_elig, tail_idx, head_idx, occupied, older_init;
    logic          accept, store_sent;
    logic          tail_q, tail_d, head_q, head_d;

    logic              load1_valid_q, load1_valid_d, load2_valid_q, load2_valid_d;
    logic [TAG_W-1:0]  load1_tag_q, load1_tag_d, load2_tag_q, load2_tag_d;
    logic [DATA_W-1:0] load1_addr_q, load1_addr_d, load2_addr_q, load2_addr_d;
    logic              store1_valid_q, store1_valid_d, store2_valid_q, store2_valid_d;
    logic [DATA_W-1:0] store1_addr_q, store1_addr_d, store2_addr_q, store2_addr_d;
    logic [DATA_W-1:0] store1_data_q, store1_data_d, store2_data_q, store2_data_d;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ent
            localparam bit               IS_ST   = (gi >= 2);
            localparam logic [TAG_W-1:0] ENT_TAG = IS_ST ? TAG_W'(STORE_TAG0 + gi - 2)
                                                         : TAG_W'(LOAD_TAG0 + gi);
            mem_rs_entry #(.IS_STORE(IS_ST), .ENT_TAG(ENT_TAG)) u_entry (
                .clk        (clk),
                .reset      (reset),
                .alloc      (alloc[gi]),
                .issue_qj   (issue_qj),
                .issue_vj   (issue_vj),
                .issue_qk   (issue_qk),
                .issue_vk   (issue_vk),
                .issue_imm  (issue_imm),
                .older_init (older_init),
                .cdb_valid  (cdb_valid),
                .cdb_tag    (cdb_tag),
                .cdb_data   (cdb_data),
                .selected   (sel[gi]),
                .store_sent (store_sent),
                .ent_o      (ent[gi])
            );
        end
    endgenerate

    // Allocation: lowest free load slot, or the store at the tail pointer.
    always_comb begin
        tail_idx    = {1'b1, tail_q};
        ld_free     = {ent[1].state == FREE, ent[0].state == FREE};
        issue_ready = issue_is_store ? (ent[tail_idx].state == FREE) : (|ld_free);
        accept      = issue_valid && issue_ready;
        alloc       = '0;
        issue_tag   = '0;
        if (accept) begin
            if (issue_is_store) begin
                alloc[tail_idx] = 1'b1;
                issue_tag       = STORE_TAG0 + TAG_W'(tail_q);
            end else if (ld_free[0]) begin
                alloc[0]  = 1'b1;
                issue_tag = LOAD_TAG0;
            end else begin
                alloc[1]  = 1'b1;
                issue_tag = LOAD_TAG0 + TAG_W'(1);
            end
        end
        tail_d = tail_q ^ (accept && issue_is_store);
    end

    // Request select (load0 > load1 > head store) and the registered request buses.
    always_comb begin
        head_idx   = {1'b1, head_q};
        ld_elig[0] = (ent[0].state == READY) && (ent[0].older_stores == 2'd0);
        ld_elig[1] = (ent[1].state == READY) && (ent[1].older_stores == 2'd0);
        sel = '0;
        if (ld_elig[0]) begin
            sel[0] = 1'b1;
        end else if (ld_elig[1]) begin
            sel[1] = 1'b1;
        end else if (ent[head_idx].state == READY) begin
            sel[head_idx] = 1'b1;
        end
        store_sent = sel[2] | sel[3];
        head_d     = head_q ^ store_sent;
        // A store leaving this cycle is not older than a load arriving this cycle.
        occupied   = 2'(ent[2].state != FREE) + 2'(ent[3].state != FREE);
        older_init = occupied - {1'b0, store_sent};

        load1_valid_d  = sel[0];
        load1_tag_d    = sel[0] ? LOAD_TAG0 : '0;
        load1_addr_d   = sel[0] ? ent[0].addr : '0;
        load2_valid_d  = sel[1];
        load2_tag_d    = sel[1] ? (LOAD_TAG0 + TAG_W'(1)) : '0;
        load2_addr_d   = sel[1] ? ent[1].addr : '0;
        store1_valid_d = sel[2];
        store1_addr_d  = sel[2] ? ent[2].addr : '0;
        store1_data_d  = sel[2] ? ent[2].vk : '0;
        store2_valid_d = sel[3];
        store2_addr_d  = sel[3] ? ent[3].addr : '0;
        store2_data_d  = sel[3] ? ent[3].vk : '0;
    end

    // Pointers and request output registers; reset drops any in-flight request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tail_q         <= 1'b0;
            head_q         <= 1'b0;
            load1_valid_q  <= 1'b0;
            load1_tag_q    <= '0;
            load1_addr_q   <= '0;
            load2_valid_q  <= 1'b0;
            load2_tag_q    <= '0;
            load2_addr_q   <= '0;
            store1_valid_q <= 1'b0;
            store1_addr_q  <= '0;
            store1_data_q  <= '0;
            store2_valid_q <= 1'b0;
            store2_addr_q  <= '0;
            store2_data_q  <= '0;
        end else begin
            tail_q         <= tail_d;
            head_q         <= head_d;
            load1_valid_q  <= load1_valid_d;
            load1_tag_q    <= load1_tag_d;
            load1_addr_q   <= load1_addr_d;
            load2_valid_q  <= load2_valid_d;
            load2_tag_q    <= load2_tag_d;
            load2_addr_q   <= load2_addr_d;
            store1_valid_q <= store1_valid_d;
            store1_addr_q  <= store1_addr_d;
            store1_data_q  <= store1_data_d;
            store2_valid_q <= store2_valid_d;
            store2_addr_q  <= store2_addr_d;
            store2_data_q  <= store2_data_d;
        end
    end

    assign load1_valid  = load1_valid_q;
    assign load1_tag    = load1_tag_q;
    assign load1_addr   = load1_addr_q;
    assign load2_valid  = load2_valid_q;
    assign load2_tag    = load2_tag_q;
    assign load2_addr   = load2_addr_q;
    assign store1_valid = store1_valid_q;
    assign store1_addr  = store1_addr_q;
    assign store1_data  = store1_data_q;
    assign store2_valid = store2_valid_q;
    assign store2_addr  = store2_addr_q;
    assign store2_data  = store2_data_q;

endmodule
